alu_seq: RTL and testbench

Parametrised multi-cycle ALU that replaces the single-cycle 8-bit ALU in the processor datapath. It accepts one packed opcode/operand vector per valid/ready handshake and returns a registered result with flags. It adds iterative MULT and DIVIDE, a high-half result port, and output backpressure. It sits between each core's decode stage and its writeback register.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with iterative multiply/divide and result backpressure
//
// Ports:
//   clk           rising-edge clock
//   reset_n_in    asynchronous active-low reset
//   opcode_inputs {opcode, input1, input2}, opcode in the MSBs
//   in_valid      opcode_inputs carries an operation
//   in_ready      block is idle and can accept an operation
//   final_output  primary result (sum/diff/low product/quotient/logic/compare)
//   result_hi     high product half or remainder, 0 otherwise
//   carry_output  ADD carry-out / SUB borrow
//   zero_flag     final_output == 0
//   div_zero      DIVIDE by zero
//   illegal_op    opcode not in the table
//   out_valid     result registers hold an unconsumed result
//   out_ready     consumer accepts the result
module alu_seq #(
    parameter int OPCODE_LENGTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_LENGTH = OPCODE_LENGTH + 2 * DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n_in,
    input  logic [VECTOR_LENGTH-1:0] opcode_inputs,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    final_output,
    output logic [DATA_WIDTH-1:0]    result_hi,
    output logic                     carry_output,
    output logic                     zero_flag,
    output logic                     div_zero,
    output logic                     illegal_op,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_LENGTH-1:0] OP_NOP  = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULT = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV  = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_ZT   = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_GT   = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] OP_LT   = OPCODE_LENGTH'(4'b1100);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [W-1:0]       a_q, b_q;
    logic               is_div;
    logic [CW-1:0]      cnt;
    // MULT: running product. DIVIDE: {remainder, dividend/quotient shift register}.
    logic [2*W-1:0]     acc;

    logic [OPCODE_LENGTH-1:0] in_op;
    logic [W-1:0]             in_a, in_b;
    assign in_op = opcode_inputs[VECTOR_LENGTH-1 -: OPCODE_LENGTH];
    assign in_a  = opcode_inputs[2*W-1 -: W];
    assign in_b  = opcode_inputs[W-1:0];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic start_iter;
    assign start_iter = ((in_op == OP_MULT) || (in_op == OP_DIV)) && (in_b != '0);

    // Results of every operation that completes on the accept edge.
    logic [W:0]   sum;
    logic [W-1:0] sc_lo, sc_hi;
    logic         sc_c, sc_dz, sc_il;

    always_comb begin
        sum   = {1'b0, in_a} + {1'b0, in_b};
        sc_lo = '0;
        sc_hi = '0;
        sc_c  = 1'b0;
        sc_dz = 1'b0;
        sc_il = 1'b0;
        case (in_op)
            OP_NOP:  ;
            OP_ADD:  {sc_c, sc_lo} = sum;
            OP_SUB:  begin
                sc_lo = in_a - in_b;
                sc_c  = (in_a < in_b);
            end
            OP_MULT: ;  // only reached here with input2 == 0, product is 0
            OP_DIV:  begin
                // only reached here with input2 == 0
                sc_lo = '1;
                sc_hi = in_a;
                sc_dz = 1'b1;
            end
            OP_AND:  sc_lo = in_a & in_b;
            OP_OR:   sc_lo = in_a | in_b;
            OP_ZT:   sc_lo = W'(in_a == '0);
            OP_GT:   sc_lo = W'(in_a > in_b);
            OP_EQ:   sc_lo = W'(in_a == in_b);
            OP_LT:   sc_lo = W'(in_a < in_b);
            default: sc_il = 1'b1;
        endcase
    end

    // One iteration step for both iterative operations.
    logic [2*W-1:0] prod_next, div_next, acc_next;
    logic [W:0]     trial, trial_diff;
    logic           ge;

    always_comb begin
        prod_next  = acc + (b_q[cnt] ? ({{W{1'b0}}, a_q} << cnt) : '0);
        // Shift the next dividend bit (MSB-first) into the partial remainder.
        trial      = {acc[2*W-1:W], acc[W-1]};
        trial_diff = trial - {1'b0, b_q};
        ge         = (trial >= {1'b0, b_q});
        div_next   = {(ge ? trial_diff[W-1:0] : trial[W-1:0]), acc[W-2:0], ge};
        acc_next   = is_div ? div_next : prod_next;
    end

    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            is_div       <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            final_output <= '0;
            result_hi    <= '0;
            carry_output <= 1'b0;
            zero_flag    <= 1'b1;
            div_zero     <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    is_div <= (in_op == OP_DIV);
                    cnt    <= '0;
                    acc    <= (in_op == OP_DIV) ? {{W{1'b0}}, in_a} : '0;
                    if (start_iter) begin
                        state <= BUSY;
                    end else begin
                        final_output <= sc_lo;
                        result_hi    <= sc_hi;
                        carry_output <= sc_c;
                        zero_flag    <= (sc_lo == '0);
                        div_zero     <= sc_dz;
                        illegal_op   <= sc_il;
                        state        <= DONE;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (cnt == CW'(W - 1)) begin
                        // Both layouts keep the low result in the low half.
                        final_output <= acc_next[W-1:0];
                        result_hi    <= acc_next[2*W-1:W];
                        carry_output <= 1'b0;
                        zero_flag    <= (acc_next[W-1:0] == '0);
                        div_zero     <= 1'b0;
                        illegal_op   <= 1'b0;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    localparam int W  = 8;
    localparam int OL = 4;
    localparam int VL = OL + 2 * W;
    localparam int M  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset_n_in = 1'b0;
    logic [VL-1:0] opcode_inputs = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  final_output;
    logic [W-1:0]  result_hi;
    logic          carry_output;
    logic          zero_flag;
    logic          div_zero;
    logic          illegal_op;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    alu_seq #(.OPCODE_LENGTH(OL), .DATA_WIDTH(W)) dut (
        .clk           (clk),
        .reset_n_in    (reset_n_in),
        .opcode_inputs (opcode_inputs),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .final_output  (final_output),
        .result_hi     (result_hi),
        .carry_output  (carry_output),
        .zero_flag     (zero_flag),
        .div_zero      (div_zero),
        .illegal_op    (illegal_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: results straight from unsigned arithmetic on integers.
    task automatic ref_op(input logic [3:0] op, input int a, input int b,
                          output int lo, output int hi, output int c,
                          output int dz, output int il, output int lat);
        int s;
        lo = 0; hi = 0; c = 0; dz = 0; il = 0; lat = 0;
        case (op)
            4'd0:  ;
            4'd1:  begin s = a + b; lo = s & M; c = s >> W; end
            4'd2:  begin lo = (a - b) & M; c = (a < b) ? 1 : 0; end
            4'd3:  begin s = a * b; lo = s & M; hi = (s >> W) & M; lat = (b != 0) ? W : 0; end
            4'd4:  begin
                if (b == 0) begin lo = M; hi = a; dz = 1; end
                else begin lo = a / b; hi = a % b; lat = W; end
            end
            4'd6:  lo = a & b;
            4'd7:  lo = a | b;
            4'd9:  lo = (a == 0) ? 1 : 0;
            4'd10: lo = (a > b) ? 1 : 0;
            4'd11: lo = (a == b) ? 1 : 0;
            4'd12: lo = (a < b) ? 1 : 0;
            default: il = 1;
        endcase
    endtask

    // Issue one op, measure latency, check results, hold for 'hold' cycles, then consume.
    task automatic run_op(input logic [3:0] op, input int a, input int b, input int hold);
        int lo, hi, c, dz, il, lat, n;
        logic busy_ok;
        logic [W-1:0] av, bv;
        ref_op(op, a, b, lo, hi, c, dz, il, lat);
        av = a[W-1:0];
        bv = b[W-1:0];
        check("in_ready_before_accept", in_ready, 1);
        opcode_inputs = {op, av, bv};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode_inputs = VL'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        check("in_ready_low_while_busy", busy_ok, 1);
        check("in_ready_low_in_done", in_ready, 0);
        check("final_output", final_output, lo);
        check("result_hi", result_hi, hi);
        check("carry_output", carry_output, c);
        check("zero_flag", zero_flag, (lo == 0) ? 1 : 0);
        check("div_zero", div_zero, dz);
        check("illegal_op", illegal_op, il);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_final_output", final_output, lo);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_consume", in_ready, 1);
        check("out_valid_after_consume", out_valid, 0);
    endtask

    initial begin
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_final_output", final_output, 0);
        check("reset_result_hi", result_hi, 0);
        check("reset_zero_flag", zero_flag, 1);
        check("reset_flags", {carry_output, div_zero, illegal_op}, 0);
        @(negedge clk);
        reset_n_in = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(4'd1, 200, 100, 0);
        run_op(4'd2, 5, 10, 0);
        run_op(4'd2, 7, 7, 0);
        run_op(4'd3, 200, 3, 0);
        run_op(4'd3, 255, 255, 0);
        run_op(4'd3, 77, 0, 0);
        run_op(4'd4, 100, 7, 0);
        run_op(4'd4, 9, 0, 0);
        run_op(4'd4, 3, 200, 0);
        run_op(4'd4, 255, 1, 0);
        run_op(4'd11, 3, 3, 5);
        run_op(4'd9, 0, 5, 0);
        run_op(4'd0, 12, 34, 0);
        run_op(4'd12, 4, 9, 0);
        run_op(4'd12, 4, 9, 0);

        // Reset during MULT iteration 4
        opcode_inputs = {4'd3, 8'd200, 8'd3};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n_in = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_final_output", final_output, 0);
        check("abort_result_hi", result_hi, 0);
        check("abort_zero_flag", zero_flag, 1);
        @(negedge clk);
        reset_n_in = 1'b1;
        @(posedge clk); #1;
        run_op(4'd15, 1, 2, 0);

        // Randomized ops, occasional zero divisors and backpressure
        for (int k = 0; k < 60; k++) begin
            int op, a, b;
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, M);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M);
            run_op(op[3:0], a, b, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
